uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_bit_timer.sv | 21 ++
 rtl/uart_rx.sv | 76 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame format, FSM state type and default bit timing shared by the UART blocks
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter that strobes at half-bit or full-bit and wraps on each strobe
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic half,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_MAX = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] FULL_MAX = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == (half ? HALF_MAX : FULL_MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with 2-flop input sync, optional parity and stop-bit checking
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
  uart_state_t state, state_n;
  logic s1, rx_s, rx_p, tick, done, par;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .half(state == START),
    .tick(tick)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    done = 1'b0;
    case (state)
      IDLE:    state_n = (rx_p && !rx_s) ? START : IDLE;
      START:   state_n = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    state_n = (tick && idx == LAST) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_n = tick ? STOP : PARITY;
      STOP: begin
        state_n = tick ? IDLE : STOP;
        done = tick;
      end
      default: state_n = IDLE;
    endcase
  end
  // synchronizer idles high so a reset never looks like a start edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1, rx_s, rx_p} <= 3'b111;
      idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {s1, rx_s, rx_p} <= {rx_in, s1, rx_s};
      data_valid <= done;
      if (state == IDLE) idx <= '0;
      else if (state == DATA && tick) begin
        shreg[idx] <= rx_s;
        idx <= idx + 1'b1;
      end
      if (state == PARITY && tick) par <= rx_s;
      if (done) begin
        data_out <= shreg;
        parity_err <= (PARITY_EN != 0) && (^{shreg, par, PARITY_ODD != 0});
        frame_err <= ~rx_s;
      end
    end
endmodule
